clock_display_scanner: RTL and testbench
========================================

// Module: clock_display_scanner
// PURPOSE
//  Display back-end for the clock top. Takes two 6-bit binary fields (hi = hour/month,
//  lo = minute/day) plus a per-digit enable mask from the mode logic. Converts each field
//  to two BCD digits with a serial shift-add-3 engine, once per frame. Time-multiplexes
//  four 7-segment digits, one digit per scan tick, and drives the colon.
// PARAMETERS
//  SEG_ACTIVE_LOW    0  1: invert segment[6:0] and colon at the output
//  DIGIT_ACTIVE_LOW  0  1: invert digit_sel[3:0] at the output
//  LZ_BLANK          0  1: blank digit 3 when hi tens == 0
// PORTS
//  clock        in   1  single system clock; all logic on posedge
//  reset        in   1  synchronous, active-low reset
//  scan_tick    in   1  one-cycle strobe; advances scan to the next digit
//  field_hi     in   6  binary value for digits 3..2 (0..63 legal)
//  field_lo     in   6  binary value for digits 1..0 (0..63 legal)
//  digit_en     in   4  bit i = 1 shows digit i; 0 keeps segments dark for digit i
//  blink_phase  in   1  1 = blank all segments this cycle (flash in set modes)
//  colon_en     in   1  request colon on
//  segment      out  7  {g,f,e,d,c,b,a}, registered
//  digit_sel    out  4  one-hot digit strobe, registered
//  colon        out  1  registered colon_en
//  busy         out  1  1 while the BCD engine is converting
// BEHAVIOUR
//  Reset (reset==0 at posedge): scan_idx=0, segment=0, digit_sel=0, colon=0, busy=0,
//   bcd bank {d3,d2,d1,d0}=0, FSM=IDLE. Polarity parameters apply after the reset values.
//  Scan: on scan_tick, scan_idx <= scan_idx+1 (mod 4, 3->0 wraps). Same edge registers
//   digit_sel <= onehot(new idx) and segment <= decode(bank[new idx]). Latency is 1 cycle
//   from tick to outputs. Outputs hold between ticks.
//  Segment gating: segment is 0 if digit_en[idx]==0, or blink_phase==1, or
//   (LZ_BLANK && idx==3 && d3==0). Gating is sampled at the tick edge only.
//  Decode: 0-9 use the standard gfedcba table (0=7'h3F, 1=7'h06, 8=7'h7F). Codes 10-15
//   cannot occur and decode to 0.
//  FSM IDLE->LOAD: taken on scan_tick when scan_idx==3 (frame wrap). LOAD snapshots
//   field_hi and field_lo.
//  LOAD->CONV_HI: 6 shift-add-3 iterations on the hi field.
//  CONV_HI->CONV_LO: 6 iterations on the lo field.
//  CONV_LO->COMMIT: writes all four digits to the bank in one cycle. COMMIT->IDLE.
//  Total conversion time is 14 cycles. busy=1 in LOAD..COMMIT.
//  Atomicity: the bank changes only in COMMIT. Ticks during busy keep scanning on old digits.
//   A wrap tick arriving while busy!=0 is dropped; no queueing.
//  Width rules: 6-bit input max 63 -> tens 6, ones 3. Tens digit is 3 bits, zero-extended.
//  Reset mid-conversion: FSM aborts to IDLE, bank cleared, snapshot discarded.
//  Simultaneous scan_tick and COMMIT: the output decode uses the pre-commit bank. The new
//   bank is visible from the next tick.
// STRUCTURE
//  clock_disp_pkg: FSM state encoding (IDLE/LOAD/CONV_HI/CONV_LO/COMMIT), NUM_DIGITS=4,
//   7-seg table constants SEG_0..SEG_9, SEG_BLANK.
//  Sub-module bin6_to_bcd: serial double-dabble. Ports: start, bin[5:0], done, tens[2:0],
//   ones[3:0]. Instanced once and reused for hi then lo.
//  Top holds scan counter, bank, gating/decode, output registers.
// TESTING
//  1 Reset, field_hi=12, field_lo=34, digit_en=F, 4 ticks 20 cycles apart -> frame 1
//    segments all SEG_0. After the wrap tick and 14 cycles, frame 2 sel 0001..1000 shows
//    4,3,2,1 (7'h66, 7'h4F, 7'h5B, 7'h06).
//  2 field_hi=63, field_lo=0 -> digits 6,3,0,0. Then 59/59 -> 5,9,5,9.
//    Busy lasts exactly 14 cycles.
//  3 digit_en=4'b1100, blink_phase toggled -> digits 1,0 dark; digits 3,2 dark only while
//    blink_phase=1; digit_sel keeps rotating.
//  4 Change field_lo mid-conversion (cycle 8 of busy) -> displayed value is the LOAD
//    snapshot. The new value appears only after the next frame.
//  5 Assert reset during CONV_LO -> next cycle busy=0, outputs 0; first frame after reset
//    shows zeros.
//  6 LZ_BLANK=1, field_hi=5 -> digit 3 dark, digit 2 = 7'h6D; SEG_ACTIVE_LOW=1 inverts
//    all of the above.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display back-end:
// conversion FSM states, digit count and the gfedcba segment table.
package clock_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CONV_HI = 3'd2,
        ST_CONV_LO = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Serial double-dabble for a 6-bit value: the start edge shifts in the first
// bit, five more edges finish the conversion, then done holds with the result.
module bin6_to_bcd (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       done,
    output logic [2:0] tens,
    output logic [3:0] ones
);

    logic [5:0] r_bin;
    logic [2:0] r_tens;
    logic [3:0] r_ones;
    logic [2:0] r_count;
    logic       r_valid;
    logic [3:0] w_ones_adj;

    // Inputs never exceed 63, so tens stays below 5 and needs no correction.
    assign w_ones_adj = (r_ones >= 4'd5) ? (r_ones + 4'd3) : r_ones;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bin   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (start) begin
            r_bin   <= {bin[4:0], 1'b0};
            r_tens  <= '0;
            r_ones  <= {3'b000, bin[5]};
            r_count <= 3'd5;
            r_valid <= 1'b1;
        end else if (r_count != 3'd0) begin
            r_bin   <= {r_bin[4:0], 1'b0};
            r_tens  <= {r_tens[1:0], w_ones_adj[3]};
            r_ones  <= {w_ones_adj[2:0], r_bin[5]};
            r_count <= r_count - 3'd1;
        end
    end

    assign done = r_valid && (r_count == 3'd0);
    assign tens = r_tens;
    assign ones = r_ones;

endmodule

// File: rtl/clock_display_scanner.sv
// Four-digit multiplexed 7-segment scanner with a once-per-frame BCD refresh.
// The digit bank changes only in COMMIT, so a scan always shows a coherent value.
module clock_display_scanner
    import clock_disp_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int DIGIT_ACTIVE_LOW = 0,
    parameter int LZ_BLANK         = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [5:0] field_hi,
    input  logic [5:0] field_lo,
    input  logic [3:0] digit_en,
    input  logic       blink_phase,
    input  logic       colon_en,
    output logic [6:0] segment,
    output logic [3:0] digit_sel,
    output logic       colon,
    output logic       busy
);

    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] SEL_INV = (DIGIT_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic       COL_INV = (SEG_ACTIVE_LOW != 0);

    state_t                          r_state;
    logic                            r_busy;
    logic [NUM_DIGITS-1:0][3:0]      r_bank;
    logic [5:0]                      r_snap_hi;
    logic [5:0]                      r_snap_lo;
    logic [2:0]                      r_hi_tens;
    logic [3:0]                      r_hi_ones;
    logic [1:0]                      r_scan_idx;
    logic [6:0]                      r_segment;
    logic [3:0]                      r_digit_sel;
    logic                            r_colon;

    logic                            w_start;
    logic [5:0]                      w_bin;
    logic                            w_done;
    logic [2:0]                      w_tens;
    logic [3:0]                      w_ones;
    logic [1:0]                      w_next_idx;
    logic                            w_blank;

    // The engine is restarted on the lo snapshot as soon as the hi result is ready.
    assign w_start = (r_state == ST_LOAD) || ((r_state == ST_CONV_HI) && w_done);
    assign w_bin   = (r_state == ST_LOAD) ? r_snap_hi : r_snap_lo;

    bin6_to_bcd u_bcd (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .bin   (w_bin),
        .done  (w_done),
        .tens  (w_tens),
        .ones  (w_ones)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_bank    <= '0;
            r_snap_hi <= '0;
            r_snap_lo <= '0;
            r_hi_tens <= '0;
            r_hi_ones <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_tick && (r_scan_idx == 2'd3)) begin
                        r_snap_hi <= field_hi;
                        r_snap_lo <= field_lo;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_CONV_HI;
                ST_CONV_HI: begin
                    if (w_done) begin
                        r_hi_tens <= w_tens;
                        r_hi_ones <= w_ones;
                        r_state   <= ST_CONV_LO;
                    end
                end
                ST_CONV_LO: begin
                    if (w_done) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_bank  <= {{1'b0, r_hi_tens}, r_hi_ones, {1'b0, w_tens}, w_ones};
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_next_idx = r_scan_idx + 2'd1;
    assign w_blank    = !digit_en[w_next_idx] || blink_phase ||
                        ((LZ_BLANK != 0) && (w_next_idx == 2'd3) && (r_bank[3] == 4'd0));

    // Reads r_bank before any same-edge commit lands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_scan_idx  <= '0;
            r_segment   <= '0;
            r_digit_sel <= '0;
            r_colon     <= 1'b0;
        end else begin
            r_colon <= colon_en;
            if (scan_tick) begin
                r_scan_idx  <= w_next_idx;
                r_digit_sel <= 4'b0001 << w_next_idx;
                r_segment   <= w_blank ? SEG_BLANK : seg_decode(r_bank[w_next_idx]);
            end
        end
    end

    assign segment   = r_segment ^ SEG_INV;
    assign digit_sel = r_digit_sel ^ SEL_INV;
    assign colon     = r_colon ^ COL_INV;
    assign busy      = r_busy;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Bench for clock_display_scanner: a default-polarity instance and an inverted,
// leading-zero-blanking instance share stimulus and are checked against a digit model.
module tb_clock_display_scanner;

    logic       clock;
    logic       rst_n;
    logic       tick;
    logic [5:0] fh;
    logic [5:0] fl;
    logic [3:0] den;
    logic       blink;
    logic       cen;

    logic [6:0] seg_a, seg_b;
    logic [3:0] sel_a, sel_b;
    logic       colon_a, colon_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    clock_display_scanner u_dut_a (
        .clock(clock), .reset(rst_n), .scan_tick(tick), .field_hi(fh), .field_lo(fl),
        .digit_en(den), .blink_phase(blink), .colon_en(cen),
        .segment(seg_a), .digit_sel(sel_a), .colon(colon_a), .busy(busy_a)
    );

    clock_display_scanner #(
        .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_dut_b (
        .clock(clock), .reset(rst_n), .scan_tick(tick), .field_hi(fh), .field_lo(fl),
        .digit_en(den), .blink_phase(blink), .colon_en(cen),
        .segment(seg_b), .digit_sel(sel_b), .colon(colon_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: displayed digits as integers, busy as a cycle countdown.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         m_idx = 0;
    int         m_bank [4] = '{0, 0, 0, 0};
    int         m_busy = 0;
    int         m_snap_hi = 0;
    int         m_snap_lo = 0;
    logic [6:0] m_seg_a = '0;
    logic [6:0] m_seg_b = '0;
    logic [3:0] m_sel = '0;
    logic       m_colon = 1'b0;

    task automatic model_step();
        int nidx;
        logic gate;
        if (!rst_n) begin
            m_idx = 0; m_busy = 0; m_seg_a = '0; m_seg_b = '0; m_sel = '0; m_colon = 1'b0;
            for (int i = 0; i < 4; i++) m_bank[i] = 0;
        end else begin
            m_colon = cen;
            nidx = (m_idx + 1) % 4;
            if (tick) begin
                gate    = !den[nidx] || blink;
                m_seg_a = gate ? 7'h00 : seg_tab[m_bank[nidx]];
                m_seg_b = (gate || (nidx == 3 && m_bank[3] == 0)) ? 7'h00 : seg_tab[m_bank[nidx]];
                m_sel   = 4'(1 << nidx);
            end
            if (m_busy == 0) begin
                if (tick && m_idx == 3) begin
                    m_busy = 14; m_snap_hi = int'(fh); m_snap_lo = int'(fl);
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_bank[3] = m_snap_hi / 10; m_bank[2] = m_snap_hi % 10;
                    m_bank[1] = m_snap_lo / 10; m_bank[0] = m_snap_lo % 10;
                end
            end
            if (tick) m_idx = nidx;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic mb;
        mb = (m_busy > 0);
        chk("seg_a",   {1'b0, seg_a},   {1'b0, m_seg_a});
        chk("sel_a",   {4'h0, sel_a},   {4'h0, m_sel});
        chk("colon_a", {7'h0, colon_a}, {7'h0, m_colon});
        chk("busy_a",  {7'h0, busy_a},  {7'h0, mb});
        chk("seg_b",   {1'b0, seg_b},   {1'b0, ~m_seg_b});
        chk("sel_b",   {4'h0, sel_b},   {4'h0, ~m_sel});
        chk("colon_b", {7'h0, colon_b}, {7'h0, ~m_colon});
        chk("busy_b",  {7'h0, busy_b},  {7'h0, mb});
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clock);
        model_step();
        #1;
        check_all();
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic tick_gap(input int gap);
        cyc(1'b1);
        idle(gap - 1);
    endtask

    task automatic frame(input int gap);
        repeat (4) tick_gap(gap);
    endtask

    task automatic sync_to_wrap();
        for (int k = 0; k < 8 && m_idx != 3; k++) tick_gap(3);
        idle(16);
    endtask

    int busy_len;

    initial begin
        rst_n = 1'b0; tick = 1'b0; fh = 6'd12; fl = 6'd34; den = 4'hF; blink = 1'b0; cen = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Frame 1 shows the reset bank; frame 2 shows 12/34.
        frame(20);
        frame(20);
        chk("t1_digit0", {1'b0, seg_a}, 8'h66);
        chk("t1_sel0", {4'h0, sel_a}, 8'h01);

        // Extremes and a typical value.
        fh = 6'd63; fl = 6'd0;
        frame(20); frame(20);
        fh = 6'd59; fl = 6'd59;
        frame(20); frame(20);

        // Conversion length measured from the wrap tick.
        sync_to_wrap();
        cyc(1'b1);
        busy_len = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy_a === 1'b1) busy_len++;
            cyc(1'b0);
        end
        chk("busy_len", 8'(busy_len), 8'd14);

        // Digit enable mask and blinking.
        den = 4'b1100;
        for (int k = 0; k < 16; k++) begin
            blink = 1'($urandom_range(0, 1));
            cen = 1'($urandom_range(0, 1));
            tick_gap(6);
        end
        den = 4'hF; blink = 1'b0; cen = 1'b1;

        // Field change mid-conversion must not affect the snapshot.
        sync_to_wrap();
        fh = 6'($urandom_range(0, 63)); fl = 6'd21;
        cyc(1'b1);
        idle(7);
        fl = 6'($urandom_range(0, 63));
        idle(10);
        frame(20); frame(20);

        // Scan tick on the commit edge decodes the old bank.
        fh = 6'd47; fl = 6'd8;
        sync_to_wrap();
        cyc(1'b1);
        idle(13);
        cyc(1'b1);
        frame(20);

        // Reset during the lo conversion.
        sync_to_wrap();
        fh = 6'd33; fl = 6'd44;
        cyc(1'b1);
        idle(10);
        rst_n = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1;
        chk("rst_busy", {7'h0, busy_a}, 8'h00);
        frame(20); frame(20);

        // Leading-zero blanking on the second instance.
        fh = 6'd5; fl = 6'($urandom_range(0, 63));
        frame(20); frame(20);

        // Random traffic, including wrap ticks dropped while busy.
        for (int k = 0; k < 600; k++) begin
            if (k % 40 == 0) begin
                fh = 6'($urandom_range(0, 63));
                fl = 6'($urandom_range(0, 63));
                den = 4'($urandom_range(0, 15));
            end
            blink = ($urandom_range(0, 7) == 0);
            cen = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 249) != 0);
            cyc(1'($urandom_range(0, 3) == 0));
        end
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
